// File: rtl/riscv_pkg.sv
// Shared RV32I encodings for the memory/writeback stage: result select,
// load/store width codes and the load/store unit state.
package riscv_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extraction/extension and alignment check.
// Purely combinational; address is the low two bits of the effective address.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wd,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic        misalign
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        be       = 4'b0000;
        wdata    = 32'h0;
        misalign = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{wd[7:0]}};
            end
            2'b01: begin
                be       = 4'b0011 << {addr_lo[1], 1'b0};
                wdata    = {2{wd[15:0]}};
                misalign = addr_lo[0];
            end
            2'b10: begin
                be       = 4'b1111;
                wdata    = wd;
                misalign = |addr_lo;
            end
            default: misalign = 1'b1;
        endcase
        // 110 decodes as a word in the low bits but has no RV32I meaning
        if (funct3 == 3'b110) begin
            misalign = 1'b1;
        end
    end

    always_comb begin
        byte_s = rdata[{addr_lo, 3'b000} +: 8];
        half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    ldata = {{24{byte_s[7]}}, byte_s};
            F3_BU:   ldata = {24'h0, byte_s};
            F3_H:    ldata = {{16{half_s[15]}}, half_s};
            F3_HU:   ldata = {16'h0, half_s};
            default: ldata = rdata;
        endcase
    end

endmodule

// File: rtl/memwb_stage.sv
// RV32I memory-access + writeback stage: req/ready data-memory handshake with
// stall and watchdog, followed by the MEM/WB register driving the register file.
module memwb_stage
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ValidM,
    input  logic            RegWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic            MemWriteM,
    input  logic [2:0]      funct3M,
    input  logic [4:0]      RdM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [XLEN-1:0] inc_PCM,
    output logic            StallM,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            RegWriteW,
    output logic [4:0]      RdW,
    output logic [XLEN-1:0] ResultW,
    output logic            misalign,
    output logic            bus_err
);

    localparam logic [7:0] TO = 8'(TIMEOUT);

    lsu_state_e      state, state_n;
    logic [7:0]      cnt, cnt_n;
    logic            memop;
    logic            mis_raw;
    logic            req_c, stall_c, berr_c;
    logic [3:0]      be_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] ldata_c;
    logic [XLEN-1:0] result_c;

    assign memop = ValidM & (MemWriteM | (ResultSrcM == RES_MEM));

    lsu_align u_align (
        .funct3   (funct3M),
        .addr_lo  (ALUResultM[1:0]),
        .wd       (WriteDataM),
        .rdata    (mem_rdata),
        .be       (be_c),
        .wdata    (wdata_c),
        .ldata    (ldata_c),
        .misalign (mis_raw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // cnt counts stalled cycles of the current access; the IDLE miss is the first
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        req_c   = 1'b0;
        stall_c = 1'b0;
        berr_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (memop && !mis_raw) begin
                    req_c = 1'b1;
                    if (!mem_ready) begin
                        stall_c = 1'b1;
                        state_n = S_WAIT;
                        cnt_n   = 8'd1;
                    end
                end
            end
            S_WAIT: begin
                if ((TIMEOUT != 0) && (cnt == TO)) begin
                    berr_c  = 1'b1;
                    state_n = S_IDLE;
                    cnt_n   = 8'd0;
                end else begin
                    req_c = 1'b1;
                    if (mem_ready) begin
                        state_n = S_IDLE;
                        cnt_n   = 8'd0;
                    end else begin
                        stall_c = 1'b1;
                        cnt_n   = cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = 8'd0;
            end
        endcase
    end

    // Request-side outputs are forced low while reset is held, even with a live M slot
    assign mem_req   = req_c & rst_n;
    assign StallM    = stall_c & rst_n;
    assign bus_err   = berr_c & rst_n;
    assign misalign  = (state == S_IDLE) & memop & mis_raw & rst_n;
    assign mem_we    = mem_req & MemWriteM;
    assign mem_addr  = mem_req ? {ALUResultM[XLEN-1:2], 2'b00} : '0;
    assign mem_be    = mem_req ? be_c : 4'b0000;
    assign mem_wdata = mem_req ? wdata_c : '0;

    always_comb begin
        case (ResultSrcM)
            RES_MEM: result_c = ldata_c;
            RES_PC4: result_c = inc_PCM;
            default: result_c = ALUResultM;
        endcase
    end

    // MEM/WB register: bubble while stalled, capture on completing/non-memory cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW <= 1'b0;
            RdW       <= 5'd0;
            ResultW   <= '0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
        end else begin
            RegWriteW <= ValidM & RegWriteM & ~misalign & ~bus_err & (RdM != 5'd0);
            RdW       <= RdM;
            ResultW   <= result_c;
        end
    end

endmodule

// File: tb/tb_memwb_stage.sv
// Directed bench for memwb_stage: single-cycle vector table plus wait-state,
// watchdog and reset-during-wait sequences.
module tb_memwb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ValidM, RegWriteM, MemWriteM, mem_ready;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, WriteDataM, inc_PCM, mem_rdata;
    logic        StallM, mem_req, mem_we, RegWriteW, misalign, bus_err;
    logic [31:0] mem_addr, mem_wdata, ResultW;
    logic [3:0]  mem_be;
    logic [4:0]  RdW;

    int checks = 0;
    int failures = 0;

    memwb_stage #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .ValidM(ValidM), .RegWriteM(RegWriteM),
        .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM), .funct3M(funct3M),
        .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .inc_PCM(inc_PCM), .StallM(StallM), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .RegWriteW(RegWriteW),
        .RdW(RdW), .ResultW(ResultW), .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        rw;
        logic [1:0]  src;
        logic        mw;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_mis;
        logic        e_rw;
        logic [31:0] e_res;
    } vec_t;

    vec_t tv [16];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] src, input logic mw,
                         input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc4, input logic rdy,
                         input logic [31:0] rdata);
        ValidM = v; RegWriteM = rw; ResultSrcM = src; MemWriteM = mw; funct3M = f3;
        RdM = rd; ALUResultM = alu; WriteDataM = wd; inc_PCM = pc4;
        mem_ready = rdy; mem_rdata = rdata;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // Load that waits three stalled cycles then completes
    task automatic wait_load(input logic [2:0] f3, input logic [31:0] exp_res, input string nm);
        @(negedge clk);
        drive(1'b1, 1'b1, 2'b01, 1'b0, f3, 5'd8, 32'h102, 32'h0, 32'h0, 1'b0, 32'h0080_0000);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk({nm, "_stall"}, {31'h0, StallM}, 32'h1);
            chk({nm, "_req"},   {31'h0, mem_req}, 32'h1);
            chk({nm, "_addr"},  mem_addr, 32'h100);
            chk({nm, "_be"},    {28'h0, mem_be}, 32'h4);
            @(posedge clk); #1;
            chk({nm, "_bubble"}, {31'h0, RegWriteW}, 32'h0);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #2;
        chk({nm, "_done_stall"}, {31'h0, StallM}, 32'h0);
        chk({nm, "_done_req"},   {31'h0, mem_req}, 32'h1);
        @(posedge clk); #1;
        chk({nm, "_rw"},  {31'h0, RegWriteW}, 32'h1);
        chk({nm, "_rd"},  {27'h0, RdW}, 32'd8);
        chk({nm, "_res"}, ResultW, exp_res);
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        //       v     rw    src    mw    f3      rd     alu            wd             pc4          rdy   rdata           req   we    addr         be       wdata          mis   rw    res
        tv[0]  = '{1'b1, 1'b1, 2'b00, 1'b0, 3'b000, 5'd5,  32'h0000_1234, 32'h0,         32'h0,       1'b0, 32'h0,          1'b0, 1'b0, 32'h0,       4'b0000, 32'h0,         1'b0, 1'b1, 32'h0000_1234};
        tv[1]  = '{1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 5'd0,  32'h0000_0103, 32'h0000_00AB, 32'h0,       1'b1, 32'h0,          1'b1, 1'b1, 32'h100,     4'b1000, 32'hABAB_ABAB, 1'b0, 1'b0, 32'h0000_0103};
        tv[2]  = '{1'b1, 1'b0, 2'b00, 1'b1, 3'b001, 5'd0,  32'h0000_0102, 32'h1234_CDEF, 32'h0,       1'b1, 32'h0,          1'b1, 1'b1, 32'h100,     4'b1100, 32'hCDEF_CDEF, 1'b0, 1'b0, 32'h0000_0102};
        tv[3]  = '{1'b1, 1'b0, 2'b00, 1'b1, 3'b010, 5'd0,  32'h0000_020C, 32'hDEAD_BEEF, 32'h0,       1'b1, 32'h0,          1'b1, 1'b1, 32'h20C,     4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_020C};
        tv[4]  = '{1'b1, 1'b1, 2'b01, 1'b0, 3'b001, 5'd7,  32'h0000_0302, 32'h0,         32'h0,       1'b1, 32'h8001_7F00,  1'b1, 1'b0, 32'h300,     4'b1100, 32'h0,         1'b0, 1'b1, 32'hFFFF_8001};
        tv[5]  = '{1'b1, 1'b1, 2'b01, 1'b0, 3'b101, 5'd7,  32'h0000_0302, 32'h0,         32'h0,       1'b1, 32'h8001_7F00,  1'b1, 1'b0, 32'h300,     4'b1100, 32'h0,         1'b0, 1'b1, 32'h0000_8001};
        tv[6]  = '{1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 5'd9,  32'h0000_0400, 32'h0,         32'h0,       1'b1, 32'h1234_5678,  1'b1, 1'b0, 32'h400,     4'b1111, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
        tv[7]  = '{1'b1, 1'b1, 2'b01, 1'b0, 3'b000, 5'd10, 32'h0000_0101, 32'h0,         32'h0,       1'b1, 32'h0000_7F00,  1'b1, 1'b0, 32'h100,     4'b0010, 32'h0,         1'b0, 1'b1, 32'h0000_007F};
        tv[8]  = '{1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 5'd3,  32'h0000_0202, 32'h0,         32'h0,       1'b1, 32'h0,          1'b0, 1'b0, 32'h0,       4'b0000, 32'h0,         1'b1, 1'b0, 32'h0};
        tv[9]  = '{1'b1, 1'b1, 2'b01, 1'b0, 3'b011, 5'd3,  32'h0000_0000, 32'h0,         32'h0,       1'b1, 32'h0,          1'b0, 1'b0, 32'h0,       4'b0000, 32'h0,         1'b1, 1'b0, 32'h0};
        tv[10] = '{1'b1, 1'b1, 2'b10, 1'b0, 3'b000, 5'd1,  32'h0000_0055, 32'h0,         32'h80,      1'b0, 32'h0,          1'b0, 1'b0, 32'h0,       4'b0000, 32'h0,         1'b0, 1'b1, 32'h0000_0080};
        tv[11] = '{1'b1, 1'b1, 2'b11, 1'b0, 3'b000, 5'd2,  32'h0000_0077, 32'h0,         32'h80,      1'b0, 32'h0,          1'b0, 1'b0, 32'h0,       4'b0000, 32'h0,         1'b0, 1'b1, 32'h0000_0077};
        tv[12] = '{1'b1, 1'b1, 2'b00, 1'b0, 3'b000, 5'd0,  32'h0000_0099, 32'h0,         32'h0,       1'b0, 32'h0,          1'b0, 1'b0, 32'h0,       4'b0000, 32'h0,         1'b0, 1'b0, 32'h0000_0099};
        tv[13] = '{1'b0, 1'b1, 2'b00, 1'b1, 3'b010, 5'd4,  32'h0000_0010, 32'h5,         32'h0,       1'b1, 32'h0,          1'b0, 1'b0, 32'h0,       4'b0000, 32'h0,         1'b0, 1'b0, 32'h0000_0010};
        tv[14] = '{1'b1, 1'b1, 2'b00, 1'b0, 3'b000, 5'd6,  32'h0000_0066, 32'h0,         32'h0,       1'b1, 32'hFFFF_FFFF,  1'b0, 1'b0, 32'h0,       4'b0000, 32'h0,         1'b0, 1'b1, 32'h0000_0066};
        tv[15] = '{1'b1, 1'b0, 2'b00, 1'b1, 3'b001, 5'd0,  32'h0000_0101, 32'h1,         32'h0,       1'b1, 32'h0,          1'b0, 1'b0, 32'h0,       4'b0000, 32'h0,         1'b1, 1'b0, 32'h0000_0101};

        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req",   {31'h0, mem_req},   32'h0);
        chk("rst_stall", {31'h0, StallM},    32'h0);
        chk("rst_rw",    {31'h0, RegWriteW}, 32'h0);
        chk("rst_rd",    {27'h0, RdW},       32'h0);
        chk("rst_res",   ResultW,            32'h0);
        chk("rst_flags", {30'h0, misalign, bus_err}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i].valid, tv[i].rw, tv[i].src, tv[i].mw, tv[i].f3, tv[i].rd,
                  tv[i].alu, tv[i].wd, tv[i].pc4, tv[i].rdy, tv[i].rdata);
            #2;
            chk($sformatf("v%0d_req", i),   {31'h0, mem_req},  {31'h0, tv[i].e_req});
            chk($sformatf("v%0d_we", i),    {31'h0, mem_we},   {31'h0, tv[i].e_we});
            chk($sformatf("v%0d_addr", i),  mem_addr,          tv[i].e_addr);
            chk($sformatf("v%0d_be", i),    {28'h0, mem_be},   {28'h0, tv[i].e_be});
            chk($sformatf("v%0d_wdata", i), mem_wdata,         tv[i].e_wdata);
            chk($sformatf("v%0d_stall", i), {31'h0, StallM},   32'h0);
            chk($sformatf("v%0d_mis", i),   {31'h0, misalign}, {31'h0, tv[i].e_mis});
            @(posedge clk); #1;
            chk($sformatf("v%0d_rw", i),  {31'h0, RegWriteW}, {31'h0, tv[i].e_rw});
            chk($sformatf("v%0d_rd", i),  {27'h0, RdW},       {27'h0, tv[i].rd});
            chk($sformatf("v%0d_res", i), ResultW,            tv[i].e_res);
        end
        @(negedge clk);
        idle_inputs();
        #2;
        chk("mis_pulse_end", {31'h0, misalign}, 32'h0);

        wait_load(3'b000, 32'hFFFF_FF80, "lb_wait");
        wait_load(3'b100, 32'h0000_0080, "lbu_wait");

        // Watchdog: four stalled cycles, then bus_err with no write
        @(negedge clk);
        drive(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 5'd4, 32'h200, 32'h0, 32'h0, 1'b0, 32'h55);
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("to_stall", {31'h0, StallM},  32'h1);
            chk("to_berr",  {31'h0, bus_err}, 32'h0);
            @(posedge clk); #1;
            chk("to_bubble", {31'h0, RegWriteW}, 32'h0);
            @(negedge clk);
        end
        #2;
        chk("to_fire_stall", {31'h0, StallM},  32'h0);
        chk("to_fire_berr",  {31'h0, bus_err}, 32'h1);
        chk("to_fire_req",   {31'h0, mem_req}, 32'h0);
        @(posedge clk); #1;
        chk("to_rw", {31'h0, RegWriteW}, 32'h0);
        @(negedge clk);
        idle_inputs();
        #2;
        chk("to_berr_end", {31'h0, bus_err}, 32'h0);
        chk("to_idle_req", {31'h0, mem_req}, 32'h0);

        // Reset asserted in the middle of a wait
        @(negedge clk);
        drive(1'b1, 1'b1, 2'b00, 1'b0, 3'b000, 5'd5, 32'h1234, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 5'd4, 32'h200, 32'h0, 32'h0, 1'b0, 32'h77);
        @(posedge clk);
        @(posedge clk); #1;
        chk("rw_pre_stall", {31'h0, StallM}, 32'h1);
        chk("rw_pre_rd",    {27'h0, RdW},    32'd5);
        rst_n = 1'b0;
        #1;
        chk("rw_req",   {31'h0, mem_req},   32'h0);
        chk("rw_stall", {31'h0, StallM},    32'h0);
        chk("rw_rw",    {31'h0, RegWriteW}, 32'h0);
        chk("rw_rd",    {27'h0, RdW},       32'h0);
        chk("rw_res",   ResultW,            32'h0);
        chk("rw_flags", {30'h0, misalign, bus_err}, 32'h0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        #2;
        chk("rw_late_req", {31'h0, mem_req}, 32'h0);
        @(posedge clk); #1;
        chk("rw_late_rw", {31'h0, RegWriteW}, 32'h0);
        @(negedge clk);
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
